// File: rtl/boot_loader.sv
// Framed byte-stream loader: writes a program image into ROM through its write port,
// verifies the checksum, then releases the CPU from reset.
module boot_loader #(
    parameter logic [7:0]  SYNC_BYTE     = 8'hA5,
    parameter int unsigned RELEASE_DELAY = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic       reload,
    output logic       rom_we,
    output logic [7:0] rom_waddr,
    output logic [7:0] rom_wdata,
    output logic       cpu_reset,
    output logic       load_done,
    output logic       load_err,
    output logic [8:0] byte_cnt
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_ADDR    = 3'd1;
    localparam logic [2:0] S_LEN     = 3'd2;
    localparam logic [2:0] S_DATA    = 3'd3;
    localparam logic [2:0] S_CSUM    = 3'd4;
    localparam logic [2:0] S_RELEASE = 3'd5;
    localparam logic [2:0] S_RUN     = 3'd6;
    localparam logic [2:0] S_ERROR   = 3'd7;

    logic [2:0] state;
    logic [7:0] addr_ptr;
    logic [8:0] remaining;
    logic [7:0] sum;
    logic [7:0] delay_cnt;
    logic       xfer;
    logic [7:0] csum_total;

    assign xfer       = in_valid & in_ready;
    assign csum_total = sum + in_data;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= S_IDLE;
            addr_ptr  <= '0;
            remaining <= '0;
            sum       <= '0;
            delay_cnt <= '0;
            in_ready  <= 1'b1;
            rom_we    <= 1'b0;
            rom_waddr <= '0;
            rom_wdata <= '0;
            cpu_reset <= 1'b1;
            load_done <= 1'b0;
            load_err  <= 1'b0;
            byte_cnt  <= '0;
        end else begin
            rom_we <= 1'b0;
            case (state)
                S_IDLE, S_ERROR: begin
                    if (xfer && in_data == SYNC_BYTE)
                        state <= S_ADDR;
                end
                S_ADDR: begin
                    if (xfer) begin
                        addr_ptr <= in_data;
                        state    <= S_LEN;
                    end
                end
                S_LEN: begin
                    if (xfer) begin
                        // LEN of zero encodes a full 256-byte page
                        remaining <= (in_data == 8'h00) ? 9'd256 : {1'b0, in_data};
                        sum       <= '0;
                        byte_cnt  <= '0;
                        state     <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (xfer) begin
                        rom_we    <= 1'b1;
                        rom_waddr <= addr_ptr;
                        rom_wdata <= in_data;
                        addr_ptr  <= addr_ptr + 8'd1;
                        sum       <= csum_total;
                        byte_cnt  <= byte_cnt + 9'd1;
                        remaining <= remaining - 9'd1;
                        if (remaining == 9'd1)
                            state <= S_CSUM;
                    end
                end
                S_CSUM: begin
                    if (xfer) begin
                        if (csum_total == 8'h00) begin
                            load_err  <= 1'b0;
                            in_ready  <= 1'b0;
                            delay_cnt <= 8'(RELEASE_DELAY - 1);
                            state     <= S_RELEASE;
                        end else begin
                            load_err <= 1'b1;
                            state    <= S_ERROR;
                        end
                    end
                end
                S_RELEASE: begin
                    if (delay_cnt == 8'd0) begin
                        cpu_reset <= 1'b0;
                        load_done <= 1'b1;
                        state     <= S_RUN;
                    end else begin
                        delay_cnt <= delay_cnt - 8'd1;
                    end
                end
                S_RUN: begin
                    if (reload) begin
                        cpu_reset <= 1'b1;
                        load_done <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
